// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: 4-bit-mode character LCD bus driver.
// Takes one 10-bit instruction {RS, RW, D7..D0} per request and sends it as two
// enable-strobed nibbles, upper first, with setup/pulse/hold/gap/execution delays.
// Ends with a one-cycle done pulse.
// Optional build macro LCD_INIT_SEQ_EN: runs the LCD power-on nibble sequence
// after reset release, before the block first reaches IDLE.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | waiting for next_instruction
// S_LATCH      | capture db, drive RS/RW/upper nibble
// S_UP_SETUP   | upper nibble setup before lcd_e rises
// S_UP_PULSE   | lcd_e high for the upper nibble
// S_UP_HOLD    | upper nibble held after lcd_e falls
// S_GAP        | spacing between the two nibbles
// S_LO_SETUP   | lower nibble setup before lcd_e rises
// S_LO_PULSE   | lcd_e high for the lower nibble
// S_LO_HOLD    | lower nibble held after lcd_e falls
// S_WAIT       | instruction execution time
// S_DONE       | done pulse, back to IDLE next cycle
// S_INIT_WAIT  | power-on delay before the next init nibble (macro only)
// S_INIT_PULSE | lcd_e high for an init nibble (macro only)

module lcd_nibble_tx #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 50,
  parameter int T_WAIT  = 2000,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next_instruction,
  input  logic [9:0] db,
  output logic       done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] sf_d
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_UP_SETUP,
    S_UP_PULSE,
    S_UP_HOLD,
    S_GAP,
    S_LO_SETUP,
    S_LO_PULSE,
    S_LO_HOLD,
    S_WAIT,
    S_DONE
`ifdef LCD_INIT_SEQ_EN
    ,
    S_INIT_WAIT,
    S_INIT_PULSE
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The counter runs N-1 down to 0, so a state lasts exactly N cycles.
  function automatic logic [CNT_W-1:0] dly(input int n);
    return CNT_W'(n - 1);
  endfunction

`ifdef LCD_INIT_SEQ_EN
  // Delay that precedes init pulse 'step'; step 4 is the final settle before IDLE.
  function automatic int init_wait(input logic [2:0] step);
    case (step)
      3'd0:    return 750000;
      3'd1:    return 205000;
      3'd2:    return 5000;
      default: return 2000;
    endcase
  endfunction

  localparam state_t           RST_STATE = S_INIT_WAIT;
  localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(750000 - 1);
  localparam logic             RST_BUSY  = 1'b1;
  logic [2:0] init_step;
`else
  localparam state_t           RST_STATE = S_IDLE;
  localparam logic [CNT_W-1:0] RST_CNT   = '0;
  localparam logic             RST_BUSY  = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic [3:0]       lo_nib;
  logic             done_d, busy_d, e_d, rs_d, rw_d;
  logic [3:0]       sf_d_d;

  // State register and per-state down-counter, reloaded on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_STATE;
      cnt   <= RST_CNT;
`ifdef LCD_INIT_SEQ_EN
      init_step <= 3'd0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= cnt_load;
      else if (cnt != '0)
        cnt <= cnt - CNT_ONE;
`ifdef LCD_INIT_SEQ_EN
      if (state == S_INIT_PULSE && state_nxt != S_INIT_PULSE)
        init_step <= init_step + 3'd1;
`endif
    end
  end

  // Next-state logic: timed states advance when the counter reaches zero.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (next_instruction) state_nxt = S_LATCH;
      S_LATCH:    state_nxt = S_UP_SETUP;
      S_UP_SETUP: if (cnt == '0) state_nxt = S_UP_PULSE;
      S_UP_PULSE: if (cnt == '0) state_nxt = S_UP_HOLD;
      S_UP_HOLD:  if (cnt == '0) state_nxt = S_GAP;
      S_GAP:      if (cnt == '0) state_nxt = S_LO_SETUP;
      S_LO_SETUP: if (cnt == '0) state_nxt = S_LO_PULSE;
      S_LO_PULSE: if (cnt == '0) state_nxt = S_LO_HOLD;
      S_LO_HOLD:  if (cnt == '0) state_nxt = S_WAIT;
      S_WAIT:     if (cnt == '0) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
`ifdef LCD_INIT_SEQ_EN
      S_INIT_WAIT:
        if (cnt == '0) state_nxt = (init_step == 3'd4) ? S_IDLE : S_INIT_PULSE;
      S_INIT_PULSE:
        if (cnt == '0) state_nxt = S_INIT_WAIT;
`endif
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Counter reload value for the state being entered.
  always_comb begin
    cnt_load = '0;
    case (state_nxt)
      S_UP_SETUP, S_LO_SETUP: cnt_load = dly(T_SETUP);
      S_UP_PULSE, S_LO_PULSE: cnt_load = dly(T_PULSE);
      S_UP_HOLD,  S_LO_HOLD:  cnt_load = dly(T_HOLD);
      S_GAP:                  cnt_load = dly(T_GAP);
      S_WAIT:                 cnt_load = dly(T_WAIT);
`ifdef LCD_INIT_SEQ_EN
      S_INIT_PULSE:           cnt_load = dly(12);
      S_INIT_WAIT:            cnt_load = dly(init_wait(init_step + 3'd1));
`endif
      default:                cnt_load = '0;
    endcase
  end

  // Output decode from the upcoming state so every pin comes straight off a flop.
  always_comb begin
    done_d = (state_nxt == S_DONE);
    busy_d = (state_nxt != S_IDLE);
    e_d    = (state_nxt == S_UP_PULSE) || (state_nxt == S_LO_PULSE);
    rs_d   = lcd_rs;
    rw_d   = lcd_rw;
    sf_d_d = sf_d;
    if (state == S_LATCH) begin
      rs_d   = db[9];
      rw_d   = db[8];
      sf_d_d = db[7:4];
    end
    if (state == S_GAP && state_nxt == S_LO_SETUP)
      sf_d_d = lo_nib;
`ifdef LCD_INIT_SEQ_EN
    // Nibble follows the pre-update step, so it changes one cycle after lcd_e falls.
    if (state == S_INIT_WAIT || state == S_INIT_PULSE) begin
      rs_d   = 1'b0;
      rw_d   = 1'b0;
      sf_d_d = (init_step < 3'd3) ? 4'h3 : 4'h2;
    end
    if (state_nxt == S_INIT_PULSE)
      e_d = 1'b1;
`endif
  end

  // Output registers plus the captured lower nibble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done   <= 1'b0;
      busy   <= RST_BUSY;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_rw <= 1'b0;
      sf_d   <= 4'h0;
      lo_nib <= 4'h0;
    end else begin
      done   <= done_d;
      busy   <= busy_d;
      lcd_e  <= e_d;
      lcd_rs <= rs_d;
      lcd_rw <= rw_d;
      sf_d   <= sf_d_d;
      if (state == S_LATCH)
        lo_nib <= db[3:0];
    end
  end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Directed bench for lcd_nibble_tx with default parameters (init sequence off).
// Edge numbers are relative to E0, the edge that samples next_instruction=1.

module tb_lcd_nibble_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       next_instruction = 1'b0;
  logic [9:0] db = '0;
  logic       done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] sf_d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lcd_nibble_tx dut (
    .clk              (clk),
    .reset            (reset),
    .next_instruction (next_instruction),
    .db               (db),
    .done             (done),
    .busy             (busy),
    .lcd_e            (lcd_e),
    .lcd_rs           (lcd_rs),
    .lcd_rw           (lcd_rw),
    .sf_d             (sf_d)
  );

  // Single comparison point: counts every vector, reports any miscompare.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_e"},    32'(lcd_e), 32'd0);
    chk({tag, "_rs"},   32'(lcd_rs), 32'd0);
    chk({tag, "_rw"},   32'(lcd_rw), 32'd0);
    chk({tag, "_sfd"},  32'(sf_d), 32'd0);
  endtask

  // Issues one instruction starting now and follows it edge by edge.
  // abort_k > 0 pulls reset low right after edge abort_k.
  // inject re-requests with different db at E500 and watches a few cycles past E2082.
  task automatic run_cmd(input string name, input logic [9:0] d, input int abort_k, input bit inject);
    int         n_done = 0;
    int         n_e = 0;
    int         bad_data = 0;
    int         bad_busy = 0;
    int         last_k;
    bit         aborted = 1'b0;
    logic [3:0] exp_nib;
    db = d;
    next_instruction = 1'b1;
    @(posedge clk); #1;
    next_instruction = 1'b0;
    last_k = inject ? 2090 : 2082;
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      if (k == 2) db = ~d;
      if (inject && k == 500) begin
        db = 10'h3C5;
        next_instruction = 1'b1;
      end
      if (inject && k == 501) next_instruction = 1'b0;
      if (k == abort_k) begin
        chk({name, "_e_before_abort"}, 32'(lcd_e), 32'd1);
        reset = 1'b0;
        #1;
        chk_rst_outs({name, "_abort"});
        aborted = 1'b1;
        break;
      end
      if (done) n_done++;
      if (lcd_e) n_e++;
      if (k <= 2081 && !busy) bad_busy++;
      exp_nib = (k < 66) ? d[7:4] : d[3:0];
      if (sf_d !== exp_nib || lcd_rs !== d[9] || lcd_rw !== d[8]) bad_data++;
      case (k)
        1:    chk({name, "_sfd_E1"}, 32'(sf_d), 32'(d[7:4]));
        2:    chk({name, "_e_E2"}, 32'(lcd_e), 32'd0);
        3:    chk({name, "_e_E3"}, 32'(lcd_e), 32'd1);
        14:   chk({name, "_e_E14"}, 32'(lcd_e), 32'd1);
        15:   chk({name, "_e_E15"}, 32'(lcd_e), 32'd0);
        65:   chk({name, "_sfd_E65"}, 32'(sf_d), 32'(d[7:4]));
        66:   chk({name, "_sfd_E66"}, 32'(sf_d), 32'(d[3:0]));
        67:   chk({name, "_e_E67"}, 32'(lcd_e), 32'd0);
        68:   chk({name, "_e_E68"}, 32'(lcd_e), 32'd1);
        79:   chk({name, "_e_E79"}, 32'(lcd_e), 32'd1);
        80:   chk({name, "_e_E80"}, 32'(lcd_e), 32'd0);
        2080: chk({name, "_done_E2080"}, 32'(done), 32'd0);
        2081: begin
          chk({name, "_done_E2081"}, 32'(done), 32'd1);
          chk({name, "_busy_E2081"}, 32'(busy), 32'd1);
        end
        2082: begin
          chk({name, "_done_E2082"}, 32'(done), 32'd0);
          chk({name, "_busy_E2082"}, 32'(busy), 32'd0);
        end
        default: ;
      endcase
    end
    if (aborted) begin
      repeat (3) @(posedge clk);
      #1;
      chk_rst_outs({name, "_held"});
      @(negedge clk);
      reset = 1'b1;
      n_done = 0;
      for (int k = 0; k < 2200; k++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      chk({name, "_no_done_after_abort"}, 32'(n_done), 32'd0);
      chk({name, "_idle_after_abort"}, 32'(busy), 32'd0);
    end else begin
      chk({name, "_done_count"}, 32'(n_done), 32'd1);
      chk({name, "_e_cycles"}, 32'(n_e), 32'd24);
      chk({name, "_data_stable"}, 32'(bad_data), 32'd0);
      chk({name, "_busy_held"}, 32'(bad_busy), 32'd0);
      if (inject) chk({name, "_no_queued_cmd"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      next_instruction = 1'($urandom);
      db = 10'($urandom);
    end
    #1;
    chk_rst_outs("reset");
    @(negedge clk);
    next_instruction = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_e", 32'(lcd_e), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    run_cmd("cmd028", 10'h028, 0, 1'b0);
    run_cmd("char_C", 10'b10_0100_0011, 0, 1'b0);
    run_cmd("repulse", 10'h1A5, 0, 1'b1);
    run_cmd("abort", 10'h306, 70, 1'b0);
    run_cmd("cmd001", 10'h001, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
